// File: rtl/counter_ctrl.sv
// Start/stop/pause counter controller with one-shot or auto-reload operation.
// state | meaning
// IDLE  | stopped, count held, waiting for start
// RUN   | counting from start value toward terminal value
// DONE  | one-shot finished, count held at terminal value
module counter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] lv_r;
  logic             up_r;
  logic             ar_r;
  logic [WIDTH-1:0] sv;
  logic [WIDTH-1:0] tv;
  logic             start_ok;

  assign sv       = up_r ? '0 : lv_r;
  assign tv       = up_r ? lv_r : '0;
  assign start_ok = start && !stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      tc    <= 1'b0;
      lv_r  <= '0;
      up_r  <= 1'b1;
      ar_r  <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (start_ok) begin
        // live inputs set the first count so restart needs no extra cycle
        state <= RUN;
        count <= up ? '0 : load_val;
        lv_r  <= load_val;
        up_r  <= up;
        ar_r  <= auto_reload;
      end else if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          RUN: begin
            if (!pause) begin
              if (count == tv) begin
                tc <= 1'b1;
                if (ar_r) count <= sv;
                else      state <= DONE;
              end else begin
                count <= up_r ? count + ONE : count - ONE;
              end
            end
          end
          IDLE, DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus random stimulus
// against a position-in-period reference model.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [7:0] load_val = '0;
  logic       up = 1'b1, auto_reload = 1'b0;
  logic [7:0] count;
  logic       busy, done, tc;

  int checks = 0;
  int fails  = 0;

  // reference model: mode 0 idle, 1 running, 2 finished
  int m_mode, m_pos, m_lv, m_cnt;
  bit m_up, m_ar, m_tc;

  counter_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .load_val(load_val), .up(up), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done), .tc(tc)
  );

  always #5 clk = ~clk;

  function automatic int cur_count();
    if (m_mode == 0) return m_cnt;
    return m_up ? m_pos : m_lv - m_pos;
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [7:0] c;
    c = 8'(cur_count());
    return {c, m_mode == 1, m_mode == 2, m_tc};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_lv = 0; m_cnt = 0; m_up = 1; m_ar = 0; m_tc = 0;
  endtask

  task automatic model_edge();
    m_tc = 0;
    if (start && !stop) begin
      m_mode = 1; m_pos = 0; m_lv = load_val; m_up = up; m_ar = auto_reload;
    end else if (stop) begin
      if (m_mode != 0) begin
        m_cnt = cur_count();
        m_mode = 0;
      end
    end else if (m_mode == 1 && !pause) begin
      if (m_pos == m_lv) begin
        m_tc = 1;
        if (m_ar) m_pos = 0;
        else      m_mode = 2;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic step(input logic s, input logic sp, input logic p,
                      input logic [7:0] lv, input logic u, input logic a);
    start = s; stop = sp; pause = p; load_val = lv; up = u; auto_reload = a;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({count, busy, done, tc} !== 11'd0) begin
      fails++;
      $display("FAIL reset: got count=%0d busy=%0b done=%0b tc=%0b, want all 0", count, busy, done, tc);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_oneshot_up();
    step(1, 0, 0, 8'd3, 1, 0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({count, busy, done, tc} !== exp_vec()) begin
        fails++;
        $display("FAIL oneshot cyc%0d: got %h want %h", i, {count, busy, done, tc}, exp_vec());
      end
      step(0, 0, 0, 8'd0, 0, 0);
    end
    checks++;
    if (count !== 8'd3 || done !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
      fails++;
      $display("FAIL oneshot_final: got count=%0d done=%0b busy=%0b tc=%0b, want 3 1 0 0", count, done, busy, tc);
    end
  endtask

  task automatic test_reload_down();
    int tc_seen = 0;
    step(1, 0, 0, 8'd2, 0, 1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({count, busy, done, tc} !== exp_vec()) begin
        fails++;
        $display("FAIL reload_down cyc%0d: got %h want %h", i, {count, busy, done, tc}, exp_vec());
      end
      if (tc) tc_seen++;
      step(0, 0, 0, 8'd0, 1, 0);
    end
    checks++;
    if (tc_seen != 3) begin
      fails++;
      $display("FAIL reload_down_tc_count: got %0d want 3", tc_seen);
    end
    step(0, 1, 0, 8'd0, 1, 0);
  endtask

  task automatic test_pause();
    int tc_edge = -1;
    step(1, 0, 0, 8'd5, 1, 0);
    for (int e = 1; e <= 10; e++) begin
      step(0, 0, (e == 3 || e == 4), 8'd0, 0, 0);
      checks++;
      if ({count, busy, done, tc} !== exp_vec()) begin
        fails++;
        $display("FAIL pause edge%0d: got %h want %h", e, {count, busy, done, tc}, exp_vec());
      end
      if (tc && tc_edge < 0) tc_edge = e;
    end
    checks++;
    if (tc_edge != 8) begin
      fails++;
      $display("FAIL pause_tc_delay: got tc at edge %0d want 8", tc_edge);
    end
  endtask

  task automatic test_start_stop();
    step(1, 0, 0, 8'd10, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'd0, 0, 0);
    step(1, 1, 0, 8'd9, 0, 1);
    checks++;
    if (count !== 8'd4 || busy !== 1'b0 || done !== 1'b0 || {count, busy, done, tc} !== exp_vec()) begin
      fails++;
      $display("FAIL start_stop_idle: got count=%0d busy=%0b want count=4 busy=0", count, busy);
    end
    step(1, 0, 0, 8'd6, 0, 0);
    checks++;
    if (count !== 8'd6 || busy !== 1'b1 || {count, busy, done, tc} !== exp_vec()) begin
      fails++;
      $display("FAIL restart_sv: got count=%0d busy=%0b want count=6 busy=1", count, busy);
    end
    step(0, 1, 0, 8'd0, 1, 0);
  endtask

  task automatic test_lv0();
    step(1, 0, 0, 8'd0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 8'd0, 0, 0);
      checks++;
      if (count !== 8'd0 || tc !== 1'b1 || {count, busy, done, tc} !== exp_vec()) begin
        fails++;
        $display("FAIL lv0 cyc%0d: got count=%0d tc=%0b want count=0 tc=1", i, count, tc);
      end
    end
    step(0, 1, 0, 8'd0, 0, 0);
    checks++;
    if (tc !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL lv0_stop: got tc=%0b busy=%0b want 0 0", tc, busy);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 8'd20, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 8'd0, 0, 0);
    checks++;
    if (count !== 8'd7 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got count=%0d busy=%0b want 7 1", count, busy);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({count, busy, done, tc} !== 11'd0) begin
      fails++;
      $display("FAIL async_reset: got count=%0d busy=%0b done=%0b tc=%0b want all 0", count, busy, done, tc);
    end
    step(1, 0, 0, 8'd4, 0, 0);
    checks++;
    if ({count, busy, done, tc} !== 11'd0) begin
      fails++;
      $display("FAIL reset_override: got %h want 0", {count, busy, done, tc});
    end
    rst = 1'b0;
    step(1, 0, 0, 8'd4, 0, 0);
    checks++;
    if (count !== 8'd4 || busy !== 1'b1 || {count, busy, done, tc} !== exp_vec()) begin
      fails++;
      $display("FAIL first_edge_start: got count=%0d busy=%0b want 4 1", count, busy);
    end
  endtask

  task automatic test_random();
    logic prev_tc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic       s, sp, p, u, a;
      logic [7:0] lv;
      s  = ($urandom_range(0, 99) < 8);
      sp = ($urandom_range(0, 99) < 4);
      p  = ($urandom_range(0, 99) < 20);
      lv = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      u  = 1'($urandom);
      a  = 1'($urandom);
      step(s, sp, p, lv, u, a);
      checks++;
      if ({count, busy, done, tc} !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc%0d: got %h want %h", i, {count, busy, done, tc}, exp_vec());
      end
      if (prev_tc && tc && !(m_lv == 0 && m_ar)) begin
        fails++;
        $display("FAIL random_tc_double cyc%0d: got tc=1 twice want single pulse", i);
      end
      prev_tc = tc;
    end
  endtask

  initial begin
    test_reset();
    test_oneshot_up();
    test_reload_down();
    test_pause();
    test_start_stop();
    test_lv0();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
